approx_adder_err_eval: RTL and testbench
========================================

// Module: approx_adder_err_eval
// PURPOSE
//  Consumer/checker end of the approximate-adder interface: sweeps every operand pair into an
//  external adder DUT, captures its sum, compares against the exact sum, accumulates error metrics.
//  Sits in the ErrorEval harness next to a generated adder_i*_o* netlist; results read by host/TB.
// PARAMETERS
//  IN_W   2           width of each operand; DUT has 2*IN_W inputs, OUT_W outputs
//  OUT_W  IN_W+1      DUT sum width (fixed relation; not independently overridable)
//  LAT    0           DUT path latency in clk cycles, 0..4 (0 = purely combinational DUT)
// PORTS
//  clk          in   1              clock, rising edge
//  rst_n        in   1              asynchronous active-low reset
//  start        in   1              pulse: begin sweep (accepted in IDLE or DONE only)
//  opa          out  IN_W           operand A to DUT (DUT low inputs)
//  opb          out  IN_W           operand B to DUT (DUT high inputs)
//  dut_sum      in   OUT_W          DUT sum, valid LAT cycles after opa/opb
//  busy         out  1              high in SWEEP/DRAIN
//  done         out  1              high in DONE; metrics stable
//  err_count    out  2*IN_W+1       number of vectors with dut_sum != exact
//  max_abs_err  out  OUT_W          max |dut_sum - exact|
//  sum_abs_err  out  2*IN_W+OUT_W   sum of |dut_sum - exact| over all vectors
// BEHAVIOUR
//  Reset: state=IDLE; opa,opb,busy,done,err_count,max_abs_err,sum_abs_err = 0; pipeline cleared.
//  FSM IDLE -start-> SWEEP -last vector driven-> DRAIN (skip if LAT=0) -LAT cycles-> DONE -start-> SWEEP.
//  Start accepted: all accumulators cleared same edge; first SWEEP cycle drives vector 0.
//  SWEEP: vector counter v (2*IN_W bits), opa=v[IN_W-1:0], opb=v[2*IN_W-1:IN_W]; v++ each cycle;
//   last vector = all ones; exactly N=2^(2*IN_W) SWEEP cycles, no wrap re-driven.
//  Exact sum = opa+opb zero-extended to OUT_W; delayed with a valid bit through LAT-stage pipe.
//  Compare when pipe-out valid: dut_sum sampled in cycle vector driven + LAT.
//  |err| = (dut_sum>=exp)?dut_sum-exp:exp-dut_sum, OUT_W bits, unsigned; err_count++ if nonzero.
//  Accumulators cannot overflow by width choice; no saturation logic.
//  DRAIN: opa/opb hold last vector; compares continue until pipe empty; done asserted after last compare.
//  DONE: metrics held; done stays high until start; start in DONE restarts (done low next cycle).
//  start while busy: ignored, no effect on sweep or metrics.
//  rst_n low mid-sweep: immediate return to reset values; partial results discarded.
//  Total start->done: 1+N+LAT cycles.
// CONFIGURATION
//  ERR_EVAL_BITFLIP_EN defined: extra output bit_flip_cnt [OUT_W*(2*IN_W+1)-1:0], per-sum-bit
//   count of vectors where dut_sum[i]!=exp[i], slice i at [i*(2*IN_W+1) +: 2*IN_W+1];
//   cleared on reset/start like other metrics.
//  Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Package err_eval_pkg: state enum (IDLE,SWEEP,DRAIN,DONE), LAT_MAX=4, width helper functions
//   for counter/accumulator widths.
//  Sub-module err_eval_exp_pipe: LAT-deep shift register of {valid, exp}, LAT=0 passthrough.
//  Top holds FSM, vector counter, compare/abs-diff, accumulators.
// TESTING
//  IN_W=2, LAT=0, exact adder model -> done after 17 cycles; err_count=0, max=0, sum=0.
//  IN_W=2, dut_sum tied 0 -> err_count=15, max_abs_err=6, sum_abs_err=48.
//  IN_W=2, dut_sum = exact|1 (bit0 stuck-1) -> err_count=8, max_abs_err=1, sum_abs_err=8.
//  LAT=2, exact adder with 2 register stages -> 0 errors, done at cycle 19;
//   same DUT with LAT=1 -> err_count nonzero.
//  start pulsed mid-SWEEP ignored; rst_n low at vector 7 -> all outputs 0, IDLE; restart gives
//   full correct results.
//  ERR_EVAL_BITFLIP_EN, dut_sum tied 0 -> bit_flip_cnt bit0=8, bit1=8, bit2=6.

Source files
------------

// File: rtl/approx_adder_err_eval_pkg.sv
// Shared types and width helpers for the approximate-adder error evaluator.
// Optional feature macro: ERR_EVAL_BITFLIP_EN (per-sum-bit flip counters).
package err_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Deepest DUT latency the drain counter is sized for.
  localparam int LAT_MAX = 4;

  // Sum width of an IN_W+IN_W adder.
  function automatic int out_w(input int in_w);
    return in_w + 1;
  endfunction

  // Vector counter width: both operands concatenated.
  function automatic int vec_w(input int in_w);
    return 2 * in_w;
  endfunction

  // Counters that can reach N = 2^(2*IN_W) need one extra bit.
  function automatic int cnt_w(input int in_w);
    return 2 * in_w + 1;
  endfunction

  // Sum of N errors each below 2^OUT_W.
  function automatic int sum_w(input int in_w);
    return 2 * in_w + out_w(in_w);
  endfunction

endpackage

// File: rtl/approx_adder_err_eval_if.sv
// Evaluator <-> DUT/host bundle. The evaluator uses the master modport.
// Optional feature macro: ERR_EVAL_BITFLIP_EN adds bit_flip_cnt.
interface approx_adder_err_eval_if
  import err_eval_pkg::*;
#(
  parameter int IN_W = 2
);
  localparam int OUT_W = out_w(IN_W);
  localparam int CNT_W = cnt_w(IN_W);
  localparam int SUM_W = sum_w(IN_W);

  logic              start;
  logic [IN_W-1:0]   opa;
  logic [IN_W-1:0]   opb;
  logic [OUT_W-1:0]  dut_sum;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  err_count;
  logic [OUT_W-1:0]  max_abs_err;
  logic [SUM_W-1:0]  sum_abs_err;

`ifdef ERR_EVAL_BITFLIP_EN
  logic [OUT_W*CNT_W-1:0] bit_flip_cnt;

  modport master (
    input  start, dut_sum,
    output opa, opb, busy, done, err_count, max_abs_err, sum_abs_err, bit_flip_cnt
  );
  modport slave (
    output start, dut_sum,
    input  opa, opb, busy, done, err_count, max_abs_err, sum_abs_err, bit_flip_cnt
  );
`else
  modport master (
    input  start, dut_sum,
    output opa, opb, busy, done, err_count, max_abs_err, sum_abs_err
  );
  modport slave (
    output start, dut_sum,
    input  opa, opb, busy, done, err_count, max_abs_err, sum_abs_err
  );
`endif

endinterface

// File: rtl/approx_adder_err_eval_exp_pipe.sv
// LAT-deep shift register carrying {valid, exact sum} alongside the DUT
// path so the reference arrives in the same cycle as dut_sum. LAT=0 is a
// plain passthrough.
module err_eval_exp_pipe #(
  parameter int W   = 3,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld_in,
  input  logic [W-1:0] exp_in,
  output logic         vld_out,
  output logic [W-1:0] exp_out
);

  if (LAT == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign vld_out = vld_in;
    assign exp_out = exp_in;
  end else begin : g_pipe
    logic [LAT-1:0] vld_q, vld_d;
    logic [W-1:0]   exp_q [LAT];
    logic [W-1:0]   exp_d [LAT];

    // Shift one stage per cycle; stage 0 takes the new entry.
    always_comb begin
      vld_d    = vld_q;
      vld_d[0] = vld_in;
      exp_d[0] = exp_in;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        exp_d[i] = exp_q[i-1];
      end
    end

    // Pipeline registers, fully cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int i = 0; i < LAT; i++) exp_q[i] <= '0;
      end else begin
        vld_q <= vld_d;
        for (int i = 0; i < LAT; i++) exp_q[i] <= exp_d[i];
      end
    end

    assign vld_out = vld_q[LAT-1];
    assign exp_out = exp_q[LAT-1];
  end

endmodule

// File: rtl/approx_adder_err_eval.sv
// Error evaluator for an external approximate adder: sweeps all operand
// pairs, compares dut_sum against the exact sum LAT cycles later and
// accumulates error count, max and total absolute error.
// Optional feature macro: ERR_EVAL_BITFLIP_EN (per-sum-bit flip counters).
module approx_adder_err_eval
  import err_eval_pkg::*;
#(
  parameter int IN_W = 2,
  parameter int LAT  = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  approx_adder_err_eval_if.master bus
);

  localparam int OUT_W = out_w(IN_W);
  localparam int VEC_W = vec_w(IN_W);
  localparam int CNT_W = cnt_w(IN_W);
  localparam int SUM_W = sum_w(IN_W);
  localparam int DRN_W = $clog2(LAT_MAX);

  localparam logic [VEC_W-1:0] V_LAST   = '1;
  localparam logic [DRN_W-1:0] DRN_LAST = (LAT > 0) ? DRN_W'(LAT - 1) : '0;

  function automatic logic [OUT_W-1:0] abs_diff(input logic [OUT_W-1:0] a,
                                                input logic [OUT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   v_q, v_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [OUT_W-1:0]   max_abs_err_q, max_abs_err_d;
  logic [SUM_W-1:0]   sum_abs_err_q, sum_abs_err_d;

  logic               start_ok;
  logic               exp_vld_in;
  logic [OUT_W-1:0]   exp_in;
  logic               cmp_vld;
  logic [OUT_W-1:0]   cmp_exp;
  logic [OUT_W-1:0]   abs_err;

  // Start only counts when no sweep is in flight.
  assign start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE));

  // Next state, vector counter and drain counter.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    drn_d   = drn_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d = SWEEP;
          v_d     = '0;
        end
      end
      SWEEP: begin
        if (v_q == V_LAST) begin
          drn_d   = '0;
          state_d = (LAT == 0) ? DONE : DRAIN;
        end else begin
          v_d = v_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == DRN_LAST) state_d = DONE;
        else                   drn_d   = drn_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SWEEP) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // FSM, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      drn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      drn_q   <= drn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Operands come straight from the vector counter, which holds the last
  // vector through DRAIN/DONE.
  assign bus.opa = v_q[IN_W-1:0];
  assign bus.opb = v_q[VEC_W-1:IN_W];
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  assign exp_vld_in = (state_q == SWEEP);
  assign exp_in     = OUT_W'(bus.opa) + OUT_W'(bus.opb);

  err_eval_exp_pipe #(
    .W   (OUT_W),
    .LAT (LAT)
  ) u_exp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_in  (exp_vld_in),
    .exp_in  (exp_in),
    .vld_out (cmp_vld),
    .exp_out (cmp_exp)
  );

  assign abs_err = abs_diff(bus.dut_sum, cmp_exp);

  // Metric accumulation: cleared on an accepted start, updated per compare.
  always_comb begin
    err_count_d   = err_count_q;
    max_abs_err_d = max_abs_err_q;
    sum_abs_err_d = sum_abs_err_q;
    if (start_ok) begin
      err_count_d   = '0;
      max_abs_err_d = '0;
      sum_abs_err_d = '0;
    end else if (cmp_vld) begin
      if (abs_err != '0)          err_count_d   = err_count_q + 1'b1;
      if (abs_err > max_abs_err_q) max_abs_err_d = abs_err;
      sum_abs_err_d = sum_abs_err_q + SUM_W'(abs_err);
    end
  end

  // Metric registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q   <= '0;
      max_abs_err_q <= '0;
      sum_abs_err_q <= '0;
    end else begin
      err_count_q   <= err_count_d;
      max_abs_err_q <= max_abs_err_d;
      sum_abs_err_q <= sum_abs_err_d;
    end
  end

  assign bus.err_count   = err_count_q;
  assign bus.max_abs_err = max_abs_err_q;
  assign bus.sum_abs_err = sum_abs_err_q;

`ifdef ERR_EVAL_BITFLIP_EN
  logic [OUT_W*CNT_W-1:0] bit_flip_cnt_q, bit_flip_cnt_d;

  // Per-sum-bit disagreement counters.
  always_comb begin
    bit_flip_cnt_d = bit_flip_cnt_q;
    if (start_ok) begin
      bit_flip_cnt_d = '0;
    end else if (cmp_vld) begin
      for (int i = 0; i < OUT_W; i++) begin
        if (bus.dut_sum[i] != cmp_exp[i])
          bit_flip_cnt_d[i*CNT_W +: CNT_W] = bit_flip_cnt_q[i*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

  // Bit-flip counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_flip_cnt_q <= '0;
    else        bit_flip_cnt_q <= bit_flip_cnt_d;
  end

  assign bus.bit_flip_cnt = bit_flip_cnt_q;
`endif

endmodule

// File: tb/tb_approx_adder_err_eval.sv
// Directed bench for approx_adder_err_eval: three evaluators (LAT 0/2/1)
// share clk/rst_n/start; the LAT=0 one sees a selectable adder model, the
// other two see an exact adder with two register stages.
// Optional feature macro: ERR_EVAL_BITFLIP_EN.
module tb_approx_adder_err_eval;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [1:0] mode;  // 0 exact, 1 tied zero, 2 exact|1

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  approx_adder_err_eval_if #(.IN_W(2)) if0 ();
  approx_adder_err_eval_if #(.IN_W(2)) if2 ();
  approx_adder_err_eval_if #(.IN_W(2)) if1 ();

  approx_adder_err_eval #(.IN_W(2), .LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  approx_adder_err_eval #(.IN_W(2), .LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));
  approx_adder_err_eval #(.IN_W(2), .LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

  assign if0.start = start;
  assign if2.start = start;
  assign if1.start = start;

  always_comb begin
    case (mode)
      2'd0:    if0.dut_sum = {1'b0, if0.opa} + {1'b0, if0.opb};
      2'd1:    if0.dut_sum = 3'd0;
      default: if0.dut_sum = ({1'b0, if0.opa} + {1'b0, if0.opb}) | 3'd1;
    endcase
  end

  logic [2:0] a2_s1, a2_s2, a1_s1, a1_s2;
  always @(posedge clk) begin
    a2_s1 <= {1'b0, if2.opa} + {1'b0, if2.opb};
    a2_s2 <= a2_s1;
    a1_s1 <= {1'b0, if1.opa} + {1'b0, if1.opb};
    a1_s2 <= a1_s1;
  end
  assign if2.dut_sum = a2_s2;
  assign if1.dut_sum = a1_s2;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start and count negedges until every evaluator reports done.
  // mid_start > 0 re-pulses start at that cycle while the sweep is busy.
  task automatic run_sweep(input int mid_start, output int d0, output int d2, output int d1);
    int n;
    n  = 0;
    d0 = -1; d2 = -1; d1 = -1;
    @(negedge clk);
    start = 1'b1;
    while ((d0 < 0 || d2 < 0 || d1 < 0) && n < 100) begin
      @(negedge clk);
      n++;
      start = (n == mid_start);
      if (n == 1) begin
        check_val("done_low_after_start", if0.done, 0);
        check_val("busy_after_start", if0.busy, 1);
      end
      if (if0.done && d0 < 0) d0 = n;
      if (if2.done && d2 < 0) d2 = n;
      if (if1.done && d1 < 0) d1 = n;
    end
    start = 1'b0;
    check_val("sweep_timeout", (n < 100), 1);
  endtask

  int d0, d2, d1;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    repeat (3) @(negedge clk);

    check_val("rst_busy", if0.busy, 0);
    check_val("rst_done", if0.done, 0);
    check_val("rst_err_count", if0.err_count, 0);
    check_val("rst_max", if0.max_abs_err, 0);
    check_val("rst_sum", if0.sum_abs_err, 0);
    check_val("rst_opa", if0.opa, 0);
    check_val("rst_opb", if0.opb, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact adders everywhere.
    mode = 2'd0;
    run_sweep(0, d0, d2, d1);
    check_val("exact_done_cycle", d0, 17);
    check_val("exact_err_count", if0.err_count, 0);
    check_val("exact_max", if0.max_abs_err, 0);
    check_val("exact_sum", if0.sum_abs_err, 0);
    check_val("lat2_done_cycle", d2, 19);
    check_val("lat2_err_count", if2.err_count, 0);
    check_val("lat2_sum", if2.sum_abs_err, 0);
    check_val("lat1_done_cycle", d1, 18);
    check_val("lat1_errs_nonzero", (if1.err_count != 0), 1);
    check_val("opa_hold_last", if0.opa, 3);
    check_val("opb_hold_last", if0.opb, 3);

    // Sum tied to zero; restart from DONE.
    mode = 2'd1;
    run_sweep(0, d0, d2, d1);
    check_val("zero_err_count", if0.err_count, 15);
    check_val("zero_max", if0.max_abs_err, 6);
    check_val("zero_sum", if0.sum_abs_err, 48);
`ifdef ERR_EVAL_BITFLIP_EN
    check_val("flip_bit0", if0.bit_flip_cnt[0 +: 5], 8);
    check_val("flip_bit1", if0.bit_flip_cnt[5 +: 5], 8);
    check_val("flip_bit2", if0.bit_flip_cnt[10 +: 5], 6);
`endif
    check_val("zero_done_held", if0.done, 1);

    // Bit 0 stuck at one.
    mode = 2'd2;
    run_sweep(0, d0, d2, d1);
    check_val("or1_err_count", if0.err_count, 8);
    check_val("or1_max", if0.max_abs_err, 1);
    check_val("or1_sum", if0.sum_abs_err, 8);

    // Start re-pulsed mid-sweep must be ignored.
    mode = 2'd1;
    run_sweep(5, d0, d2, d1);
    check_val("midstart_done_cycle", d0, 17);
    check_val("midstart_err_count", if0.err_count, 15);
    check_val("midstart_sum", if0.sum_abs_err, 48);

    // Reset while vector 7 is driven.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check_val("v7_opa", if0.opa, 3);
    check_val("v7_opb", if0.opb, 1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", if0.busy, 0);
    check_val("midrst_done", if0.done, 0);
    check_val("midrst_err_count", if0.err_count, 0);
    check_val("midrst_max", if0.max_abs_err, 0);
    check_val("midrst_sum", if0.sum_abs_err, 0);
    check_val("midrst_opa", if0.opa, 0);
    check_val("midrst_opb", if0.opb, 0);
    @(negedge clk);
    @(negedge clk);
    check_val("midrst_idle_busy", if0.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(0, d0, d2, d1);
    check_val("after_rst_done_cycle", d0, 17);
    check_val("after_rst_err_count", if0.err_count, 15);
    check_val("after_rst_max", if0.max_abs_err, 6);
    check_val("after_rst_sum", if0.sum_abs_err, 48);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
